// File: rtl/antirrebote_pkg.sv
// antirrebote_pkg: shared defaults and counter width helper for the
// N-channel debouncer (antirrebote_multi / antirrebote_canal).
package antirrebote_pkg;

    localparam int CICLOS_ESTABLE_DEF = 240000;
    localparam int CICLOS_LARGO_DEF   = 24000000;
    localparam int SINC_ETAPAS_DEF    = 2;

    // Width of a counter that must hold 0 .. n-1.
    // Never returns less than one bit so tiny windows still elaborate.
    function automatic int ancho_contador(input int n);
        if (n <= 2)
            return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// antirrebote_canal: one debouncer channel. Synchroniser chain, stability
// window counter, registered edge strobes and, with the macro
// ANTIRREBOTE_PULSO_LARGO_EN, a one-shot long-press strobe.
// Ports:
//   clk, rst (sync, active high)
//   senal_entrada   raw asynchronous pin
//   salida_limpia   debounced level
//   flanco_subida   1-cycle strobe on 0->1 of salida_limpia
//   flanco_bajada   1-cycle strobe on 1->0 of salida_limpia
//   pulsacion_larga 1-cycle long-press strobe (macro only)
module antirrebote_canal
    import antirrebote_pkg::*;
#(
    parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF,
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
    parameter int CICLOS_LARGO   = CICLOS_LARGO_DEF,
`endif
    parameter int SINC_ETAPAS    = SINC_ETAPAS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic senal_entrada,
    output logic salida_limpia,
    output logic flanco_subida,
    output logic flanco_bajada
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
    ,
    output logic pulsacion_larga
`endif
);

    localparam int ANCHO = ancho_contador(CICLOS_ESTABLE);
    localparam logic [ANCHO-1:0] TOPE = ANCHO'(CICLOS_ESTABLE - 1);

    // Synchroniser: oldest stage is the only one the filter looks at.
    logic [SINC_ETAPAS-1:0] r_sinc;
    logic                   w_s;

    logic             r_cand;
    logic [ANCHO-1:0] r_cnt;
    logic             r_sal;
    logic             r_sub;
    logic             r_baj;

    logic             w_cand_d;
    logic [ANCHO-1:0] w_cnt_d;
    logic             w_sal_d;
    logic             w_sub_d;
    logic             w_baj_d;

    assign w_s = r_sinc[SINC_ETAPAS-1];

    always_ff @(posedge clk) begin
        if (rst)
            r_sinc <= '0;
        else
            r_sinc <= {r_sinc[SINC_ETAPAS-2:0], senal_entrada};
    end

    // Any difference restarts the window; once the window is full the
    // candidate is accepted and the matching strobe fires with it.
    always_comb begin
        w_cand_d = r_cand;
        w_cnt_d  = r_cnt;
        w_sal_d  = r_sal;
        w_sub_d  = 1'b0;
        w_baj_d  = 1'b0;
        if (w_s != r_cand) begin
            w_cand_d = w_s;
            w_cnt_d  = '0;
        end else if (r_cnt < TOPE) begin
            w_cnt_d = r_cnt + 1'b1;
        end else if (r_sal != r_cand) begin
            w_sal_d = r_cand;
            w_sub_d = r_cand;
            w_baj_d = ~r_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= 1'b0;
            r_cnt  <= '0;
            r_sal  <= 1'b0;
            r_sub  <= 1'b0;
            r_baj  <= 1'b0;
        end else begin
            r_cand <= w_cand_d;
            r_cnt  <= w_cnt_d;
            r_sal  <= w_sal_d;
            r_sub  <= w_sub_d;
            r_baj  <= w_baj_d;
        end
    end

    assign salida_limpia = r_sal;
    assign flanco_subida = r_sub;
    assign flanco_bajada = r_baj;

`ifdef ANTIRREBOTE_PULSO_LARGO_EN
    localparam int ANCHO_L = ancho_contador(CICLOS_LARGO);
    localparam logic [ANCHO_L-1:0] TOPE_L = ANCHO_L'(CICLOS_LARGO - 1);

    logic [ANCHO_L-1:0] r_largo_cnt;
    logic               r_largo_hecho;
    logic               r_largo;
    logic               w_largo_dispara;

    // The done flag keeps a saturated counter from re-firing until the
    // level drops and a new press qualifies.
    assign w_largo_dispara = (r_largo_cnt == TOPE_L) && !r_largo_hecho;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_largo_cnt   <= '0;
            r_largo_hecho <= 1'b0;
            r_largo       <= 1'b0;
        end else if (!r_sal) begin
            r_largo_cnt   <= '0;
            r_largo_hecho <= 1'b0;
            r_largo       <= 1'b0;
        end else begin
            r_largo <= w_largo_dispara;
            if (r_largo_cnt != TOPE_L)
                r_largo_cnt <= r_largo_cnt + 1'b1;
            if (w_largo_dispara)
                r_largo_hecho <= 1'b1;
        end
    end

    assign pulsacion_larga = r_largo;
`endif

endmodule

// File: rtl/antirrebote_multi.sv
// antirrebote_multi: CANALES independent debouncer channels.
// Optional long-press strobe under macro ANTIRREBOTE_PULSO_LARGO_EN.
// Ports:
//   clk, rst (sync, active high)
//   senal_entrada   [CANALES] raw pins
//   salida_limpia   [CANALES] debounced levels
//   flanco_subida   [CANALES] rising strobes
//   flanco_bajada   [CANALES] falling strobes
//   pulsacion_larga [CANALES] long-press strobes (macro only)
module antirrebote_multi
    import antirrebote_pkg::*;
#(
    parameter int CANALES        = 4,
    parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF,
    parameter int SINC_ETAPAS    = SINC_ETAPAS_DEF,
    parameter int CICLOS_LARGO   = CICLOS_LARGO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CANALES-1:0] senal_entrada,
    output logic [CANALES-1:0] salida_limpia,
    output logic [CANALES-1:0] flanco_subida,
    output logic [CANALES-1:0] flanco_bajada
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
    ,
    output logic [CANALES-1:0] pulsacion_larga
`endif
);

    // Channels are only built for a legal configuration; an illegal one
    // leaves the outputs undriven so it is caught at elaboration/lint.
    localparam bit PARAMS_OK = (CANALES >= 1) &&
                               (CICLOS_ESTABLE >= 2) &&
                               (SINC_ETAPAS >= 2) &&
                               (CICLOS_LARGO >= 2);

    if (PARAMS_OK) begin : g_ok
        for (genvar i = 0; i < CANALES; i++) begin : g_canal
            antirrebote_canal #(
                .CICLOS_ESTABLE (CICLOS_ESTABLE),
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
                .CICLOS_LARGO   (CICLOS_LARGO),
`endif
                .SINC_ETAPAS    (SINC_ETAPAS)
            ) u_canal (
                .clk             (clk),
                .rst             (rst),
                .senal_entrada   (senal_entrada[i]),
                .salida_limpia   (salida_limpia[i]),
                .flanco_subida   (flanco_subida[i]),
                .flanco_bajada   (flanco_bajada[i])
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
                ,
                .pulsacion_larga (pulsacion_larga[i])
`endif
            );
        end
    end

endmodule

// File: doc/antirrebote_multi.md
# antirrebote_multi

Parametrised N-channel debouncer for push-buttons and switches: each channel is synchronised, filtered against a programmable stability window, and presented as a clean level plus single-cycle rising/falling edge strobes. It sits directly behind the board's button/switch pins and feeds the control FSMs, which consume the edge strobes instead of building their own edge detectors.

## Interface
- `CANALES`, 4: number of independent channels (≥1).
- `CICLOS_ESTABLE`, 240000: consecutive stable cycles required to accept a new level (≥2).
- `SINC_ETAPAS`, 2: synchroniser flip-flop stages per channel (≥2).
- `CICLOS_LARGO`, 24000000: hold time for the long-press strobe. Only used with `ANTIRREBOTE_PULSO_LARGO_EN`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `senal_entrada`  in  CANALES  raw asynchronous inputs, one bit per channel.
- `salida_limpia`  out  CANALES  debounced levels.
- `flanco_subida`  out  CANALES  1-cycle strobe when `salida_limpia[i]` goes 0→1.
- `flanco_bajada`  out  CANALES  1-cycle strobe when `salida_limpia[i]` goes 1→0.
- `pulsacion_larga`  out  CANALES  1-cycle long-press strobe. The port exists only with the macro defined.

## Operation
- Channels are fully independent. The description below applies per channel `i`.
- Synchroniser: a chain of `SINC_ETAPAS` FFs. Its output is `s`.
- State per channel: `candidato` (1 bit), `contador` (width `$clog2(CICLOS_ESTABLE)`), and `salida_limpia`.
- Each edge, in priority order:
  - `s != candidato`: `candidato <= s`, `contador <= 0`.
  - else if `contador < CICLOS_ESTABLE-1`: `contador++`.
  - else (saturated): if `salida_limpia != candidato`, then `salida_limpia <= candidato` and assert the matching edge strobe for one cycle.
- The counter saturates at `CICLOS_ESTABLE-1` and never wraps.
- Any bounce resets the window. A pulse shorter than `CICLOS_ESTABLE` cycles at `s` never reaches the output.
- Edge strobes are registered and asserted on the same edge where `salida_limpia` changes. At most one strobe is active per channel per cycle.
- Reset (any cycle, including mid-window) clears to 0: synchroniser FFs, `candidato`, `contador`, `salida_limpia`, both strobes, and the long-press state. The first post-reset level is then qualified from scratch. An input held high through reset produces `flanco_subida` after the full window.
- Arithmetic is unsigned. The comparison is against the constant `CICLOS_ESTABLE-1` at counter width.

## Timing
- Latency: a pin level first sampled at edge 0, then held stable, appears on `salida_limpia` after edge `SINC_ETAPAS+CICLOS_ESTABLE`. The strobe is high for exactly that one cycle.
- Release latency is identical to press latency.
- Every output is a direct flop output, with no combinational path from input to output.
- Simultaneous changes on several channels are handled independently in the same cycle.

## Configuration
- `ANTIRREBOTE_PULSO_LARGO_EN` defined:
  - Adds the `pulsacion_larga` port and a per-channel hold counter of width `$clog2(CICLOS_LARGO)`.
  - The hold counter clears whenever `salida_limpia[i]==0`, increments while it is 1, and saturates.
  - `pulsacion_larga[i]` pulses for one cycle when the counter reaches `CICLOS_LARGO-1`. Only one pulse is produced per press; the next pulse requires release and re-qualification.
- Not defined: no port, no hold counter, no extra logic.

## Structure
- Package `antirrebote_pkg`:
  - default constants `CICLOS_ESTABLE_DEF=240000`, `CICLOS_LARGO_DEF=24000000`, `SINC_ETAPAS_DEF=2`;
  - width helper function for counters.
- Sub-module `antirrebote_canal`: one channel (synchroniser, window counter, edge strobes, optional long-press).
  - The top instantiates `CANALES` copies in a generate loop and concatenates their outputs.

## Test plan
Bench parameters: `CANALES=2`, `CICLOS_ESTABLE=4`, `SINC_ETAPAS=2` (and `CICLOS_LARGO=10` with the macro defined).
- Clean press:
  - Stimulus: ch0 0→1 sampled at edge 0, held.
  - Response: `salida_limpia[0]` is 1 after edge 6; `flanco_subida[0]` is high for exactly the cycle after edge 6; ch1 stays 0.
- Bounce:
  - Stimulus: ch0 toggles 1,0,1,0 on alternate cycles, then holds 1.
  - Response: no output change during bouncing; one `flanco_subida` at 6 edges after the last toggle; zero spurious strobes.
- Glitch:
  - Stimulus: ch1 high for 3 cycles, then low.
  - Response: `salida_limpia[1]` stays 0; no strobes.
- Release:
  - Stimulus: after a qualified press, ch0 goes 1→0 and holds.
  - Response: `salida_limpia[0]` falls after 6 edges; one `flanco_bajada`; `flanco_subida` stays 0.
- Reset mid-window:
  - Stimulus: `rst` asserted 2 cycles after ch0 rises, released, input kept high.
  - Response: all outputs 0 during reset; `flanco_subida[0]` arrives 6 edges after the first post-reset sample.
- Long press (macro defined):
  - Stimulus: ch0 held high for 30 cycles.
  - Response: exactly one `pulsacion_larga[0]` pulse, 10 cycles after `salida_limpia[0]` rises.
  - Without the macro, the port is absent and the build still passes.
